rate_select: RTL and testbench

RATE_SELECT -- requirements
Module: rate_select

---
 rtl/clkdvd_pkg.sv | 48 ++++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/rate_select.sv | 175 +++++++++++++++++
 tb/tb_rate_select.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdvd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkdvd_pkg
//  Description : Shared definitions for the clock-divider rate selector and
//                the downstream divider. Holds the 2-bit Gray-coded divider
//                select encodings, the selector control-FSM state type and
//                the Gray step helper used to walk the select ring.
//  Revision    : 1.0 - initial release
// ============================================================================
package clkdvd_pkg;

    // Divider select encodings. Adjacent ratios differ in exactly one bit,
    // so the downstream divider never decodes a transient foreign ratio.
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_DIV2  = 2'b00;
    localparam sel_t SEL_DIV4  = 2'b01;
    localparam sel_t SEL_DIV8  = 2'b11;
    localparam sel_t SEL_DIV16 = 2'b10;

    // Selector control FSM states.
    //   ST_IDLE    : neither button debounced high
    //   ST_HOLD_UP : only up debounced high (auto-repeat forward)
    //   ST_HOLD_DN : only down debounced high (auto-repeat backward)
    //   ST_LOCK    : both debounced high, stepping suppressed
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD_UP = 2'd1,
        ST_HOLD_DN = 2'd2,
        ST_LOCK    = 2'd3
    } state_t;

    // One position along the ring DIV2 -> DIV4 -> DIV8 -> DIV16 -> DIV2
    // (fwd=1) or the reverse (fwd=0). Any input maps to a valid code.
    function automatic sel_t sel_step(input sel_t cur, input logic fwd);
        sel_t nxt;
        nxt = cur;
        case (cur)
            SEL_DIV2:  nxt = fwd ? SEL_DIV4  : SEL_DIV16;
            SEL_DIV4:  nxt = fwd ? SEL_DIV8  : SEL_DIV2;
            SEL_DIV8:  nxt = fwd ? SEL_DIV16 : SEL_DIV4;
            default:   nxt = fwd ? SEL_DIV2  : SEL_DIV8;
        endcase
        return nxt;
    endfunction

endpackage : clkdvd_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Push-button conditioner. A raw asynchronous button is
//                brought into the clk domain through a 2-flop synchronizer,
//                then filtered by a run-length counter: the debounced level
//                only flips after DEBOUNCE_CYCLES consecutive synchronized
//                samples disagree with it. A one-cycle rise pulse marks each
//                0->1 flip of the debounced level.
//  Ports       : clk      - clock, rising edge active
//                rst      - asynchronous active-high reset
//                i_btn    - raw bouncing button, high = pressed
//                o_level  - debounced level (registered)
//                o_rise   - one-cycle pulse, high in the cycle after the
//                           edge on which o_level went 0->1 (registered,
//                           coincident with o_level first reading high)
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    // The counter only ever holds 0..DEBOUNCE_CYCLES-1; it clears on the
    // edge that would take it to DEBOUNCE_CYCLES.
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                // Any agreeing sample restarts the run.
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                // This edge completes DEBOUNCE_CYCLES disagreeing samples.
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/rate_select.sv
`default_nettype none
// ============================================================================
//  Module      : rate_select
//  Description : Two-button rate selector for the downstream clock divider.
//                Each button is synchronized and debounced; a control FSM
//                turns debounced presses into single Gray-code steps of the
//                divider select and auto-repeats while one button is held.
//                Pressing both buttons locks the selection until both are
//                released.
//  Ports       : clk     - sole clock, rising edge active
//                rst     - asynchronous active-high reset
//                btn_up  - raw button, high = pressed, steps forward
//                btn_dn  - raw button, high = pressed, steps backward
//                sel     - registered divider select (00=/2 01=/4 11=/8 10=/16)
//                sel_chg - one-cycle pulse in the cycle sel takes a new value
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_select
    import clkdvd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1024,
    parameter int REPEAT_PERIOD   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [1:0] sel,
    output logic       sel_chg
);

    // ------------------------------------------------------------------
    // Repeat counter sizing. The counter counts cycles since the last step
    // issued in a HOLD state and never exceeds the larger interval minus 1.
    // ------------------------------------------------------------------
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                              : REPEAT_PERIOD;
    localparam int                 c_RPT_W       = $clog2(c_RPT_MAX + 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_ONE     = c_RPT_W'(1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_up_level;
    logic w_up_rise;
    logic w_dn_level;
    logic w_dn_rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbnc_up (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_up),
        .o_level (w_up_level),
        .o_rise  (w_up_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbnc_dn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_dn),
        .o_level (w_dn_level),
        .o_rise  (w_dn_rise)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered select and change pulse
    // ------------------------------------------------------------------
    state_t             r_state;
    sel_t               r_sel;
    logic               r_sel_chg;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               r_rpt_first;   // next repeat is the initial (long) one

    logic [c_RPT_W-1:0] w_rpt_target;
    logic               w_rpt_hit;

    // The counter holds (cycles since the last step - 1), so a hit on the
    // target means this edge is exactly DELAY or PERIOD cycles later.
    assign w_rpt_target = r_rpt_first ? c_DELAY_LAST : c_PERIOD_LAST;
    assign w_rpt_hit    = (r_rpt_cnt == w_rpt_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= SEL_DIV2;
            r_sel_chg   <= 1'b0;
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else begin
            r_sel_chg <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Repeat timing always starts fresh on entry to HOLD.
                    r_rpt_cnt   <= '0;
                    r_rpt_first <= 1'b1;
                    if (w_up_rise && w_dn_rise) begin
                        r_state <= ST_LOCK;
                    end else if (w_up_rise) begin
                        r_state   <= ST_HOLD_UP;
                        r_sel     <= sel_step(r_sel, 1'b1);
                        r_sel_chg <= 1'b1;
                    end else if (w_dn_rise) begin
                        r_state   <= ST_HOLD_DN;
                        r_sel     <= sel_step(r_sel, 1'b0);
                        r_sel_chg <= 1'b1;
                    end
                end

                ST_HOLD_UP: begin
                    if (w_dn_level) begin
                        // Second button joins: suppress stepping, drop any
                        // pending repeat.
                        r_state   <= ST_LOCK;
                        r_rpt_cnt <= '0;
                    end else if (!w_up_level) begin
                        r_state   <= ST_IDLE;
                        r_rpt_cnt <= '0;
                    end else if (w_rpt_hit) begin
                        r_sel       <= sel_step(r_sel, 1'b1);
                        r_sel_chg   <= 1'b1;
                        r_rpt_cnt   <= '0;
                        r_rpt_first <= 1'b0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + c_RPT_ONE;
                    end
                end

                ST_HOLD_DN: begin
                    if (w_up_level) begin
                        r_state   <= ST_LOCK;
                        r_rpt_cnt <= '0;
                    end else if (!w_dn_level) begin
                        r_state   <= ST_IDLE;
                        r_rpt_cnt <= '0;
                    end else if (w_rpt_hit) begin
                        r_sel       <= sel_step(r_sel, 1'b0);
                        r_sel_chg   <= 1'b1;
                        r_rpt_cnt   <= '0;
                        r_rpt_first <= 1'b0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + c_RPT_ONE;
                    end
                end

                ST_LOCK: begin
                    // Stay locked until both buttons are released, even if
                    // one of them is let go earlier.
                    r_rpt_cnt   <= '0;
                    r_rpt_first <= 1'b1;
                    if (!w_up_level && !w_dn_level) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_rpt_cnt   <= '0;
                    r_rpt_first <= 1'b1;
                end
            endcase
        end
    end

    assign sel     = r_sel;
    assign sel_chg = r_sel_chg;

endmodule : rate_select
`default_nettype wire

// File: tb/tb_rate_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rate_select
//  Description : Self-checking bench for rate_select with short debounce and
//                repeat intervals. A behavioural model predicts sel/sel_chg
//                every cycle from sampled button history (sliding windows
//                for debounce, press timestamps for auto-repeat); directed
//                scenarios add fixed expectations on step counts and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_select;

    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [1:0] sel;
    logic       sel_chg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rate_select #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .sel     (sel),
        .sel_chg (sel_chg)
    );

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    logic [1:0] ring [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    bit   hist_u[$];
    bit   hist_d[$];
    bit   m_deb_u, m_deb_d, m_rise_u, m_rise_d;
    int   m_mode;       // 0 idle, 1 holding up, 2 holding down, 3 both held
    int   m_idx;
    int   m_t = 0;      // rising-edge counter
    int   m_press_t;
    logic [1:0] m_sel;
    logic m_chg;

    // Observations gathered every cycle
    int   dev_cnt = 0;
    int   dev_t;
    logic [1:0] dev_sel, dev_exp;
    logic dev_chg, dev_echg;
    int   chg_times[$];
    int   dbl_cnt = 0;
    bit   prev_chg = 0;

    function automatic bit window_flips(input bit q[$], input bit lvl);
        // The oldest DEB samples exclude the two still inside the synchronizer.
        for (int k = 0; k < DEB; k++)
            if (q[k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist_u.delete();
        hist_d.delete();
        for (int k = 0; k < DEB + 2; k++) begin
            hist_u.push_back(1'b0);
            hist_d.push_back(1'b0);
        end
        m_deb_u = 0; m_deb_d = 0; m_rise_u = 0; m_rise_d = 0;
        m_mode = 0; m_idx = 0; m_sel = ring[0]; m_chg = 1'b0;
    endtask

    task automatic model_step(input bit fwd);
        m_idx = fwd ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
        m_sel = ring[m_idx];
        m_chg = 1'b1;
    endtask

    function automatic bit repeat_due();
        int dt;
        dt = m_t - m_press_t;
        return (dt >= RD) && (((dt - RD) % RP) == 0);
    endfunction

    task automatic model_edge(input bit ru, input bit rd);
        m_chg = 1'b0;
        // Decisions use the debounce results of the previous edge.
        case (m_mode)
            0: begin
                if (m_rise_u && m_rise_d) m_mode = 3;
                else if (m_rise_u) begin m_mode = 1; m_press_t = m_t; model_step(1'b1); end
                else if (m_rise_d) begin m_mode = 2; m_press_t = m_t; model_step(1'b0); end
            end
            1: begin
                if (m_deb_d) m_mode = 3;
                else if (!m_deb_u) m_mode = 0;
                else if (repeat_due()) model_step(1'b1);
            end
            2: begin
                if (m_deb_u) m_mode = 3;
                else if (!m_deb_d) m_mode = 0;
                else if (repeat_due()) model_step(1'b0);
            end
            default: if (!m_deb_u && !m_deb_d) m_mode = 0;
        endcase
        hist_u.push_back(ru);
        hist_d.push_back(rd);
        while (hist_u.size() > DEB + 2) void'(hist_u.pop_front());
        while (hist_d.size() > DEB + 2) void'(hist_d.pop_front());
        m_rise_u = 0;
        m_rise_d = 0;
        if (window_flips(hist_u, m_deb_u)) begin m_deb_u = !m_deb_u; m_rise_u = m_deb_u; end
        if (window_flips(hist_d, m_deb_d)) begin m_deb_d = !m_deb_d; m_rise_d = m_deb_d; end
    endtask

    // One clock: advance the model on the rising edge, observe at the falling edge.
    task automatic tick();
        bit ru, rd;
        @(posedge clk);
        ru = btn_up;
        rd = btn_dn;
        m_t++;
        if (rst) model_reset();
        else     model_edge(ru, rd);
        @(negedge clk);
        if (sel !== m_sel || sel_chg !== m_chg) begin
            if (dev_cnt == 0) begin
                dev_t = m_t; dev_sel = sel; dev_exp = m_sel; dev_chg = sel_chg; dev_echg = m_chg;
            end
            dev_cnt++;
        end
        if (sel_chg === 1'b1) begin
            chg_times.push_back(m_t);
            if (prev_chg) dbl_cnt++;
        end
        prev_chg = (sel_chg === 1'b1);
    endtask

    task automatic hold(input bit u, input bit d, input int n);
        btn_up = u;
        btn_dn = d;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        dev_cnt = 0;
        chg_times.delete();
    endtask

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        hold(0, 0, 3);
        checks++;
        if (sel !== 2'b00) begin failures++; $display("FAIL reset_sel: got %b want 00", sel); end
        checks++;
        if (sel_chg !== 1'b0) begin failures++; $display("FAIL reset_chg: got %b want 0", sel_chg); end
        rst = 1'b0;
        dev_cnt = 0;
        chg_times.delete();
    endtask

    task automatic test_short_press();
        dev_cnt = 0; chg_times.delete();
        hold(1, 0, 3);
        hold(0, 0, 15);
        checks++;
        if (chg_times.size() != 0) begin failures++; $display("FAIL short_press_pulses: got %0d want 0", chg_times.size()); end
        checks++;
        if (sel !== 2'b00) begin failures++; $display("FAIL short_press_sel: got %b want 00", sel); end
        checks++;
        if (dev_cnt != 0) begin failures++;
            $display("FAIL short_press_model: %0d cycles off, edge %0d sel=%b want %b chg=%b want %b", dev_cnt, dev_t, dev_sel, dev_exp, dev_chg, dev_echg); end
    endtask

    task automatic test_bounce();
        int settle;
        dev_cnt = 0; chg_times.delete();
        for (int b = 0; b < 3; b++) begin
            hold(1, 0, 2);
            hold(0, 0, 2);
        end
        btn_up = 1'b1;
        tick();
        settle = m_t;              // edge that first samples the settled level
        hold(1, 0, 4);
        hold(0, 0, 15);
        checks++;
        if (chg_times.size() != 1) begin failures++; $display("FAIL bounce_pulses: got %0d want 1", chg_times.size()); end
        checks++;
        if (chg_times.size() >= 1 && chg_times[0] != settle + DEB + 2) begin failures++;
            $display("FAIL bounce_latency: pulse at edge %0d want %0d", chg_times[0], settle + DEB + 2); end
        checks++;
        if (sel !== 2'b01) begin failures++; $display("FAIL bounce_sel: got %b want 01", sel); end
        checks++;
        if (dev_cnt != 0) begin failures++;
            $display("FAIL bounce_model: %0d cycles off, edge %0d sel=%b want %b chg=%b want %b", dev_cnt, dev_t, dev_sel, dev_exp, dev_chg, dev_echg); end
    endtask

    task automatic test_dn_presses();
        logic [1:0] want [4];
        want[0] = 2'b10; want[1] = 2'b11; want[2] = 2'b01; want[3] = 2'b00;
        pulse_reset();
        for (int p = 0; p < 4; p++) begin
            // Held 4..7 samples: long enough to debounce, released before repeat.
            hold(0, 1, int'($urandom_range(4, 7)));
            hold(0, 0, 12);
            checks++;
            if (sel !== want[p]) begin failures++; $display("FAIL dn_press_%0d_sel: got %b want %b", p, sel, want[p]); end
        end
        checks++;
        if (chg_times.size() != 4) begin failures++; $display("FAIL dn_press_pulses: got %0d want 4", chg_times.size()); end
        checks++;
        if (dev_cnt != 0) begin failures++;
            $display("FAIL dn_press_model: %0d cycles off, edge %0d sel=%b want %b chg=%b want %b", dev_cnt, dev_t, dev_sel, dev_exp, dev_chg, dev_echg); end
    endtask

    task automatic test_repeat();
        int offs [7] = '{0, 8, 12, 16, 20, 24, 28};
        pulse_reset();
        hold(1, 0, 30);
        hold(0, 0, 15);
        checks++;
        if (chg_times.size() != 7) begin failures++; $display("FAIL repeat_pulses: got %0d want 7", chg_times.size()); end
        for (int k = 1; k < 7; k++) begin
            if (k < chg_times.size()) begin
                checks++;
                if (chg_times[k] - chg_times[0] != offs[k]) begin failures++;
                    $display("FAIL repeat_offset_%0d: got %0d want %0d", k, chg_times[k] - chg_times[0], offs[k]); end
            end
        end
        checks++;
        if (sel !== 2'b10) begin failures++; $display("FAIL repeat_final_sel: got %b want 10", sel); end
        checks++;
        if (dev_cnt != 0) begin failures++;
            $display("FAIL repeat_model: %0d cycles off, edge %0d sel=%b want %b chg=%b want %b", dev_cnt, dev_t, dev_sel, dev_exp, dev_chg, dev_echg); end
    endtask

    task automatic test_both();
        pulse_reset();
        hold(1, 1, 10);
        hold(0, 1, 10);
        hold(0, 0, 15);
        checks++;
        if (chg_times.size() != 0) begin failures++; $display("FAIL both_lock_pulses: got %0d want 0", chg_times.size()); end
        checks++;
        if (sel !== 2'b00) begin failures++; $display("FAIL both_lock_sel: got %b want 00", sel); end
        hold(0, 1, 6);
        hold(0, 0, 12);
        checks++;
        if (sel !== 2'b10) begin failures++; $display("FAIL both_fresh_dn_sel: got %b want 10", sel); end
        checks++;
        if (dev_cnt != 0) begin failures++;
            $display("FAIL both_model: %0d cycles off, edge %0d sel=%b want %b chg=%b want %b", dev_cnt, dev_t, dev_sel, dev_exp, dev_chg, dev_echg); end
    endtask

    task automatic test_rst_repeat();
        int rel;
        pulse_reset();
        hold(1, 0, 20);            // press step plus repeats already issued
        rst = 1'b1;                // asynchronous, between edges
        model_reset();
        #1;
        checks++;
        if (sel !== 2'b00) begin failures++; $display("FAIL rst_async_sel: got %b want 00", sel); end
        checks++;
        if (sel_chg !== 1'b0) begin failures++; $display("FAIL rst_async_chg: got %b want 0", sel_chg); end
        tick();
        tick();
        rst = 1'b0;
        rel = m_t;                 // edge rel+1 is the first to sample the held button
        chg_times.delete();
        dev_cnt = 0;
        hold(1, 0, 20);
        checks++;
        if (chg_times.size() != 3) begin failures++; $display("FAIL rst_rel_pulses: got %0d want 3", chg_times.size()); end
        checks++;
        if (chg_times.size() >= 1 && chg_times[0] != rel + 1 + DEB + 2) begin failures++;
            $display("FAIL rst_rel_first_step: edge %0d want %0d", chg_times[0], rel + 1 + DEB + 2); end
        checks++;
        if (chg_times.size() >= 2 && chg_times[1] - chg_times[0] != RD) begin failures++;
            $display("FAIL rst_rel_repeat_restart: gap %0d want %0d", chg_times[1] - chg_times[0], RD); end
        hold(0, 0, 15);
        checks++;
        if (dev_cnt != 0) begin failures++;
            $display("FAIL rst_model: %0d cycles off, edge %0d sel=%b want %b chg=%b want %b", dev_cnt, dev_t, dev_sel, dev_exp, dev_chg, dev_echg); end
    endtask

    task automatic test_random();
        pulse_reset();
        dbl_cnt = 0;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end
        hold(0, 0, 15);
        checks++;
        if (dev_cnt != 0) begin failures++;
            $display("FAIL random_model: %0d cycles off, edge %0d sel=%b want %b chg=%b want %b", dev_cnt, dev_t, dev_sel, dev_exp, dev_chg, dev_echg); end
        checks++;
        if (dbl_cnt != 0) begin failures++; $display("FAIL random_back_to_back_chg: got %0d want 0", dbl_cnt); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short_press();
        test_bounce();
        test_dn_presses();
        test_repeat();
        test_both();
        test_rst_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rate_select
`default_nettype wire
